// File: rtl/dispense_pkg.sv
// Shared definitions for the dispense command link: state codes, FSM encoding, clock rate.
package dispense_pkg;

  localparam int CLK_HZ = 12_000_000;

  // Dispenser state codes carried on the 3-bit code lines.
  localparam logic [2:0] CODE_0   = 3'd0;
  localparam logic [2:0] CODE_1   = 3'd1;
  localparam logic [2:0] CODE_2   = 3'd2;
  localparam logic [2:0] CODE_3   = 3'd3;
  localparam logic [2:0] CODE_4   = 3'd4;
  localparam logic [2:0] CODE_5   = 3'd5;
  localparam logic [2:0] CODE_6   = 3'd6;
  localparam logic [2:0] RESERVED = 3'd7;

  // Handshake sequencer states.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ASSERT  = 3'd2,
    S_RELEASE = 3'd3,
    S_RECOVER = 3'd4
  } fsm_state_t;

  // True for the code that must never be put on the link.
  function automatic logic is_reserved(input logic [2:0] code);
    return (code == RESERVED);
  endfunction

endpackage

// File: rtl/dispense_cmd_tx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; resets to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;

  // Shift the asynchronous input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_r <= d;
      q      <= meta_r;
    end
  end

endmodule

// File: rtl/dispense_cmd_tx.sv
// Initiator for the dispense command link: drives code/amount, strobes candyflag,
// and runs a four-phase handshake against the synchronized acknowledge.
module dispense_cmd_tx
  import dispense_pkg::*;
#(
  parameter int SETUP_CYCLES   = 12,
  parameter int TIMEOUT_CYCLES = 12_000_000
) (
  input  logic       clk_x1,
  input  logic       rstn,
  input  logic       cmd_valid,
  input  logic [2:0] cmd_state,
  input  logic [1:0] cmd_amount,
  output logic       cmd_ready,
  output logic [2:0] teststate,
  output logic [1:0] stateamount,
  output logic       candyflag,
  input  logic       signalrecieved,
  output logic       done,
  output logic       timeout,
  output logic       bad_cmd
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  // Compare against N-1 because the counter is cleared on the edge that enters the phase.
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  fsm_state_t    state_r, state_nxt;
  logic [CW-1:0] cnt_r, cnt_nxt;
  logic [2:0]    teststate_nxt;
  logic [1:0]    stateamount_nxt;
  logic          candyflag_nxt;
  logic          done_nxt;
  logic          timeout_nxt;
  logic          bad_cmd_nxt;
  logic          ack_s;

  sync_2ff u_ack_sync (
    .clk   (clk_x1),
    .rst_n (rstn),
    .d     (signalrecieved),
    .q     (ack_s)
  );

  // Ready is decoded straight from the state register so a command can land on any IDLE edge.
  assign cmd_ready = (state_r == S_IDLE);

  // Next-state, counter and registered-output decode for the handshake sequencer.
  always_comb begin
    state_nxt       = state_r;
    cnt_nxt         = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
    teststate_nxt   = teststate;
    stateamount_nxt = stateamount;
    candyflag_nxt   = candyflag;
    done_nxt        = 1'b0;
    timeout_nxt     = 1'b0;
    bad_cmd_nxt     = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (cmd_valid) begin
          if (is_reserved(cmd_state)) begin
            // Reserved code is consumed without touching the bus.
            bad_cmd_nxt = 1'b1;
          end else begin
            teststate_nxt   = cmd_state;
            stateamount_nxt = cmd_amount;
            cnt_nxt         = CNT_ZERO;
            state_nxt       = S_SETUP;
          end
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          candyflag_nxt = 1'b1;
          cnt_nxt       = CNT_ZERO;
          state_nxt     = S_ASSERT;
        end else begin
          state_nxt = S_SETUP;
        end
      end
      S_ASSERT: begin
        // A stale acknowledge already high here is taken as the acknowledge.
        if (ack_s) begin
          candyflag_nxt = 1'b0;
          cnt_nxt       = CNT_ZERO;
          state_nxt     = S_RELEASE;
        end else if (cnt_r == TMO_LAST) begin
          candyflag_nxt = 1'b0;
          timeout_nxt   = 1'b1;
          state_nxt     = S_RECOVER;
        end else begin
          state_nxt = S_ASSERT;
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          done_nxt  = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt_r == TMO_LAST) begin
          timeout_nxt = 1'b1;
          state_nxt   = S_RECOVER;
        end else begin
          state_nxt = S_RELEASE;
        end
      end
      S_RECOVER: begin
        // No time limit: the link must be quiet before the next command goes out.
        if (!ack_s) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_RECOVER;
        end
      end
      default: begin
        candyflag_nxt = 1'b0;
        state_nxt     = S_IDLE;
      end
    endcase
  end

  // State, counter and all link/status outputs are registered here.
  always_ff @(posedge clk_x1 or negedge rstn) begin
    if (!rstn) begin
      state_r     <= S_IDLE;
      cnt_r       <= CNT_ZERO;
      teststate   <= 3'd0;
      stateamount <= 2'd0;
      candyflag   <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      bad_cmd     <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cnt_r       <= cnt_nxt;
      teststate   <= teststate_nxt;
      stateamount <= stateamount_nxt;
      candyflag   <= candyflag_nxt;
      done        <= done_nxt;
      timeout     <= timeout_nxt;
      bad_cmd     <= bad_cmd_nxt;
    end
  end

endmodule

// File: tb/tb_dispense_cmd_tx.sv
// Self-checking bench for dispense_cmd_tx: table of commands plus handshake corner cases,
// with a responder model and an event scoreboard.
module tb_dispense_cmd_tx;

  localparam int SETUP = 4;
  localparam int TMO   = 50;
  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_TMO  = 2'd1;
  localparam logic [1:0] K_BAD  = 2'd2;
  localparam int M_NORMAL = 0;
  localparam int M_SILENT = 1;
  localparam int M_STUCK  = 2;

  logic       clk_x1 = 1'b0;
  logic       rstn = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [2:0] cmd_state = 3'd0;
  logic [1:0] cmd_amount = 2'd0;
  logic       signalrecieved = 1'b0;
  logic       cmd_ready;
  logic [2:0] teststate;
  logic [1:0] stateamount;
  logic       candyflag;
  logic       done;
  logic       timeout;
  logic       bad_cmd;

  typedef struct {
    logic [2:0] ts;
    logic [1:0] amt;
    logic [1:0] kind;
    logic       tmo_from_fall;
  } exp_t;

  typedef struct {
    logic [2:0] st;
    logic [1:0] amt;
    logic [2:0] exp_ts;
    logic [1:0] exp_amt;
    logic [1:0] kind;
  } vec_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rise_cyc = 0;
  int   fall_cyc = 0;
  int   n_done = 0;
  int   n_tmo = 0;
  int   n_bad = 0;
  int   rsp_mode = M_NORMAL;
  logic prev_flag = 1'b0;

  dispense_cmd_tx #(
    .SETUP_CYCLES   (SETUP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_x1         (clk_x1),
    .rstn           (rstn),
    .cmd_valid      (cmd_valid),
    .cmd_state      (cmd_state),
    .cmd_amount     (cmd_amount),
    .cmd_ready      (cmd_ready),
    .teststate      (teststate),
    .stateamount    (stateamount),
    .candyflag      (candyflag),
    .signalrecieved (signalrecieved),
    .done           (done),
    .timeout        (timeout),
    .bad_cmd        (bad_cmd)
  );

  always #5 clk_x1 = ~clk_x1;

  always @(posedge clk_x1) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_x1);
    #1;
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (!cmd_ready && k < 500) begin
      tick(1);
      k++;
    end
    if (!cmd_ready) check("ready_wait", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic send(input logic [2:0] st, input logic [1:0] amt, input exp_t e);
    wait_ready();
    cmd_valid  = 1'b1;
    cmd_state  = st;
    cmd_amount = amt;
    sb_q.push_back(e);
    tick(1);
    cmd_valid  = 1'b0;
    cmd_state  = 3'($urandom_range(0, 7));
    cmd_amount = 2'($urandom_range(0, 3));
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((sb_q.size() != 0 || !cmd_ready) && k < budget) begin
      tick(1);
      k++;
    end
    check("drain", sb_q.size(), 32'd0);
  endtask

  // Responder: raise ack 3 cycles into the flag, drop it 3 cycles after the flag falls.
  initial begin
    int hi;
    int lo;
    hi = 0;
    lo = 0;
    forever begin
      @(posedge clk_x1);
      #1;
      if (!rstn || rsp_mode == M_SILENT) begin
        hi = 0;
        lo = 0;
        signalrecieved = 1'b0;
      end else if (candyflag) begin
        hi++;
        lo = 0;
        if (hi >= 3) signalrecieved = 1'b1;
      end else begin
        hi = 0;
        if (signalrecieved && rsp_mode != M_STUCK) begin
          lo++;
          if (lo >= 3) begin
            signalrecieved = 1'b0;
            lo = 0;
          end
        end
      end
    end
  end

  // Monitor: timing of the flag, bus stability, and scoreboard of completion events.
  initial begin
    exp_t e;
    logic [1:0] kind;
    forever begin
      @(negedge clk_x1);
      if (!rstn) begin
        prev_flag = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) acc_cyc = cyc + 1;
        if (candyflag && !prev_flag) begin
          rise_cyc = cyc;
          check("setup_len", cyc - acc_cyc, SETUP);
        end
        if (!candyflag && prev_flag) fall_cyc = cyc;
        if (candyflag && sb_q.size() != 0) check("flag_window_ts", {29'd0, teststate}, {29'd0, sb_q[0].ts});
        if (done || timeout || bad_cmd) begin
          kind = done ? K_DONE : (timeout ? K_TMO : K_BAD);
          if (done) n_done++;
          if (timeout) n_tmo++;
          if (bad_cmd) n_bad++;
          if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL unexpected_event: got kind %0d, expected no event (cycle %0d)", kind, cyc);
          end else begin
            e = sb_q.pop_front();
            check("event_kind", {30'd0, kind}, {30'd0, e.kind});
            check("ev_teststate", {29'd0, teststate}, {29'd0, e.ts});
            check("ev_stateamount", {30'd0, stateamount}, {30'd0, e.amt});
            if (e.kind == K_TMO)
              check("timeout_delay", cyc - (e.tmo_from_fall ? fall_cyc : rise_cyc), TMO);
            if (e.kind != K_DONE) check("ev_flag_low", {31'd0, candyflag}, 32'd0);
            else check("ready_with_done", {31'd0, cmd_ready}, 32'd1);
          end
        end
        prev_flag = candyflag;
      end
    end
  end

  initial begin
    vec_t tbl[9];
    tbl[0] = '{3'd2, 2'd1, 3'd2, 2'd1, K_DONE};
    for (int i = 0; i < 7; i++) tbl[i + 1] = '{3'(i), 2'd3, 3'(i), 2'd3, K_DONE};
    tbl[8] = '{3'd7, 2'd2, 3'd6, 2'd3, K_BAD};

    // Reset values, including ready while held in reset.
    tick(3);
    check("rst_teststate", {29'd0, teststate}, 32'd0);
    check("rst_stateamount", {30'd0, stateamount}, 32'd0);
    check("rst_candyflag", {31'd0, candyflag}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_bad_cmd", {31'd0, bad_cmd}, 32'd0);
    check("rst_ready", {31'd0, cmd_ready}, 32'd1);
    rstn = 1'b1;
    tick(2);

    // Table: first command, all legal codes back to back, then a reserved code.
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].st, tbl[i].amt, '{tbl[i].exp_ts, tbl[i].exp_amt, tbl[i].kind, 1'b0});
      drain(200);
      check("tbl_teststate", {29'd0, teststate}, {29'd0, tbl[i].exp_ts});
      check("tbl_stateamount", {30'd0, stateamount}, {30'd0, tbl[i].exp_amt});
      check("tbl_ready", {31'd0, cmd_ready}, 32'd1);
      check("tbl_flag", {31'd0, candyflag}, 32'd0);
    end
    check("done_count", n_done, 32'd8);
    check("tmo_count", n_tmo, 32'd0);
    check("bad_count", n_bad, 32'd1);

    // Silent responder: timeout out of ASSERT, straight back to IDLE.
    rsp_mode = M_SILENT;
    send(3'd5, 2'd2, '{3'd5, 2'd2, K_TMO, 1'b0});
    drain(300);
    check("silent_flag", {31'd0, candyflag}, 32'd0);
    check("silent_ready", {31'd0, cmd_ready}, 32'd1);
    check("silent_no_done", n_done, 32'd8);
    check("silent_tmo", n_tmo, 32'd1);

    // Stuck acknowledge: timeout out of RELEASE, held in RECOVER until ack drops.
    rsp_mode = M_STUCK;
    send(3'd4, 2'd1, '{3'd4, 2'd1, K_TMO, 1'b1});
    for (int k = 0; k < 300 && n_tmo < 2; k++) tick(1);
    check("stuck_tmo_seen", n_tmo, 32'd2);
    tick(10);
    check("recover_ready_low", {31'd0, cmd_ready}, 32'd0);
    check("recover_flag", {31'd0, candyflag}, 32'd0);
    rsp_mode = M_NORMAL;
    drain(100);
    check("recover_ready_high", {31'd0, cmd_ready}, 32'd1);
    check("recover_no_done", n_done, 32'd8);

    // Reserved code leaves the bus holding the previous command.
    send(3'd7, 2'd0, '{3'd4, 2'd1, K_BAD, 1'b0});
    drain(20);
    tick(3);
    check("bad_flag", {31'd0, candyflag}, 32'd0);
    check("bad_teststate", {29'd0, teststate}, 32'd4);
    check("bad_count2", n_bad, 32'd2);

    // Reset while the flag is high drops it without a clock edge.
    send(3'd1, 2'd0, '{3'd1, 2'd0, K_DONE, 1'b0});
    for (int k = 0; k < 50 && !candyflag; k++) tick(1);
    check("mid_flag_up", {31'd0, candyflag}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async_flag", {31'd0, candyflag}, 32'd0);
    check("async_teststate", {29'd0, teststate}, 32'd0);
    check("async_stateamount", {30'd0, stateamount}, 32'd0);
    check("async_done", {31'd0, done}, 32'd0);
    check("async_timeout", {31'd0, timeout}, 32'd0);
    check("async_bad", {31'd0, bad_cmd}, 32'd0);
    check("async_ready", {31'd0, cmd_ready}, 32'd1);
    sb_q.delete();
    tick(2);
    rstn = 1'b1;
    tick(10);
    send(3'd6, 2'd2, '{3'd6, 2'd2, K_DONE, 1'b0});
    drain(200);
    check("post_rst_done", n_done, 32'd9);
    check("post_rst_teststate", {29'd0, teststate}, 32'd6);
    check("post_rst_stateamount", {30'd0, stateamount}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
